mont_constant_streamer: RTL and testbench

Supplies the per-modulus constants to the Montgomery exponentiation datapath as word and bit streams. It is loaded once per key with n², the Montgomery constant k and the exponent n, then presents the current block of each on its outputs. It advances each stream independently when the consumer pulses the matching `consumed_*` input, wrapping to block 0 after the last one. It is the source end of the `consumed_k` / `consumed_n_squared` / `consumed_n` fetch protocol. Its `n_squared_out` / `k_out` / `n_bit_out` feed the exponentiator's `n_squared_in` / `k_in` / `n_bit_in`.

---
 rtl/mont_constant_streamer.sv | 165 ++++++++++++++++
 tb/tb_mont_constant_streamer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mont_constant_streamer.sv
// rtl/mont_constant_streamer.sv - n^2 / k / n constant streams for the Montgomery exponentiator (optional checker: PROTOCOL_CHECK_EN)
module mont_constant_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     load_valid_in,
  input  logic [1:0]               load_sel_in,
  input  logic [REGISTER_SIZE-1:0] load_data_in,
  input  logic                     consumed_n_squared_in,
  input  logic                     consumed_k_in,
  input  logic                     consumed_n_in,
  output logic [REGISTER_SIZE-1:0] n_squared_out,
  output logic [REGISTER_SIZE-1:0] k_out,
  output logic                     n_bit_out,
  output logic                     ready_out,
  output logic                     error_out
);

  localparam int NUM_BLOCKS = 2 * BITS_IN_NUM / REGISTER_SIZE;
  localparam int N_WORDS    = BITS_IN_NUM / REGISTER_SIZE;
  localparam int PTR_W      = $clog2(NUM_BLOCKS);
  localparam int NW_W       = $clog2(N_WORDS);
  localparam int NB_W       = $clog2(BITS_IN_NUM);
  localparam int BIT_W      = $clog2(REGISTER_SIZE);

  localparam logic [PTR_W-1:0] LAST_BLK  = PTR_W'(NUM_BLOCKS - 1);
  localparam logic [NW_W-1:0]  LAST_WORD = NW_W'(N_WORDS - 1);
  localparam logic [NB_W-1:0]  LAST_BIT  = NB_W'(BITS_IN_NUM - 1);

  logic [REGISTER_SIZE-1:0] nsq_mem [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] k_mem   [NUM_BLOCKS];
  logic [REGISTER_SIZE-1:0] n_mem   [N_WORDS];

  logic [PTR_W-1:0] nsq_wr, nsq_rd, k_wr, k_rd;
  logic [NW_W-1:0]  n_wr;
  logic [NB_W-1:0]  n_rd;
  logic             nsq_loaded, k_loaded, n_loaded;

  logic             ld_nsq, ld_k, ld_n;
  logic             adv_nsq, adv_k, adv_n;
  logic [PTR_W-1:0] nsq_next, k_next;
  logic [NB_W-1:0]  n_next;

  assign ready_out = nsq_loaded & k_loaded & n_loaded;

  assign ld_nsq = load_valid_in && (load_sel_in == 2'd0);
  assign ld_k   = load_valid_in && (load_sel_in == 2'd1);
  assign ld_n   = load_valid_in && (load_sel_in == 2'd2);

  // A load to a table always beats a consume of the same table
  assign adv_nsq = consumed_n_squared_in && ready_out && !ld_nsq;
  assign adv_k   = consumed_k_in         && ready_out && !ld_k;
  assign adv_n   = consumed_n_in         && ready_out && !ld_n;

  assign nsq_next = (nsq_rd == LAST_BLK) ? '0 : nsq_rd + 1'b1;
  assign k_next   = (k_rd   == LAST_BLK) ? '0 : k_rd + 1'b1;
  assign n_next   = (n_rd   == LAST_BIT) ? '0 : n_rd + 1'b1;

  // Table storage: written only by loads, deliberately not reset
  always_ff @(posedge clk_in) begin
    if (ld_nsq) nsq_mem[nsq_wr] <= load_data_in;
    if (ld_k)   k_mem[k_wr]     <= load_data_in;
    if (ld_n)   n_mem[n_wr]     <= load_data_in;
  end

  // n^2 stream: word-0 load restarts the table, consume steps one word
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      nsq_wr        <= '0;
      nsq_rd        <= '0;
      nsq_loaded    <= 1'b0;
      n_squared_out <= '0;
    end else if (ld_nsq) begin
      if (nsq_wr == '0) begin
        nsq_loaded    <= 1'b0;
        nsq_rd        <= '0;
        n_squared_out <= load_data_in;
      end
      if (nsq_wr == LAST_BLK) begin
        nsq_loaded <= 1'b1;
        nsq_wr     <= '0;
      end else begin
        nsq_wr <= nsq_wr + 1'b1;
      end
    end else if (adv_nsq) begin
      nsq_rd        <= nsq_next;
      n_squared_out <= nsq_mem[nsq_next];
    end
  end

  // k stream: same shape as n^2
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      k_wr     <= '0;
      k_rd     <= '0;
      k_loaded <= 1'b0;
      k_out    <= '0;
    end else if (ld_k) begin
      if (k_wr == '0) begin
        k_loaded <= 1'b0;
        k_rd     <= '0;
        k_out    <= load_data_in;
      end
      if (k_wr == LAST_BLK) begin
        k_loaded <= 1'b1;
        k_wr     <= '0;
      end else begin
        k_wr <= k_wr + 1'b1;
      end
    end else if (adv_k) begin
      k_rd  <= k_next;
      k_out <= k_mem[k_next];
    end
  end

  // n bit stream: read pointer is a bit index, upper part selects the word
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      n_wr      <= '0;
      n_rd      <= '0;
      n_loaded  <= 1'b0;
      n_bit_out <= 1'b0;
    end else if (ld_n) begin
      if (n_wr == '0) begin
        n_loaded  <= 1'b0;
        n_rd      <= '0;
        n_bit_out <= load_data_in[0];
      end
      if (n_wr == LAST_WORD) begin
        n_loaded <= 1'b1;
        n_wr     <= '0;
      end else begin
        n_wr <= n_wr + 1'b1;
      end
    end else if (adv_n) begin
      n_rd      <= n_next;
      n_bit_out <= n_mem[n_next[NB_W-1:BIT_W]][n_next[BIT_W-1:0]];
    end
  end

`ifdef PROTOCOL_CHECK_EN
  logic error_q;
  logic early_consume;
  logic bad_select;

  assign early_consume = (consumed_n_squared_in | consumed_k_in | consumed_n_in) && !ready_out;
  assign bad_select    = load_valid_in && (load_sel_in == 2'd3);

  // Sticky protocol error flag
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      error_q <= 1'b0;
    end else if (early_consume || bad_select) begin
      error_q <= 1'b1;
    end
  end

  assign error_out = error_q;
`else
  assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_mont_constant_streamer.sv
// tb/tb_mont_constant_streamer.sv - self-checking bench for mont_constant_streamer
module tb_mont_constant_streamer;

  localparam int RS = 32;
  localparam int BN = 64;
`ifdef PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [1:0]    load_sel = 2'd0;
  logic [RS-1:0] load_data = '0;
  logic          c_nsq = 1'b0, c_k = 1'b0, c_n = 1'b0;
  logic [RS-1:0] n_squared, k_val;
  logic          n_bit, ready, error;

  mont_constant_streamer #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .load_valid_in(load_valid),
    .load_sel_in(load_sel),
    .load_data_in(load_data),
    .consumed_n_squared_in(c_nsq),
    .consumed_k_in(c_k),
    .consumed_n_in(c_n),
    .n_squared_out(n_squared),
    .k_out(k_val),
    .n_bit_out(n_bit),
    .ready_out(ready),
    .error_out(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          c_nsq, c_k, c_n;
    logic [RS-1:0] e_nsq, e_k;
    logic          e_nbit, e_ready, e_err;
  } vec_t;

  vec_t       tbl [69];
  vec_t       sb  [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       exp_err = 1'b0;
  logic [63:0] nval = 64'h8000_0000_0000_0005;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    c_nsq = v.c_nsq;
    c_k   = v.c_k;
    c_n   = v.c_n;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("vec_nsq",   n_squared, e.e_nsq);
    check("vec_k",     k_val,     e.e_k);
    check("vec_nbit",  n_bit,     e.e_nbit);
    check("vec_ready", ready,     e.e_ready);
    check("vec_err",   error,     e.e_err);
  endtask

  task automatic load_word(input logic [1:0] sel, input logic [RS-1:0] data);
    @(negedge clk);
    load_valid = 1'b1;
    load_sel   = sel;
    load_data  = data;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic pulse(input logic pn2, input logic pk, input logic pn);
    @(negedge clk);
    c_nsq = pn2;
    c_k   = pk;
    c_n   = pn;
    @(posedge clk);
    #1;
    c_nsq = 1'b0;
    c_k   = 1'b0;
    c_n   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      tbl[i] = '{c_nsq: 1'b0, c_k: 1'b1, c_n: 1'b0, e_nsq: 32'hA0,
                 e_k: 32'hB0 + 32'((i + 1) % 4), e_nbit: 1'b1, e_ready: 1'b1, e_err: 1'b0};
    end
    for (int j = 0; j < 64; j++) begin
      tbl[5 + j] = '{c_nsq: 1'b0, c_k: 1'b0, c_n: 1'b1, e_nsq: 32'hA0,
                     e_k: 32'hB1, e_nbit: nval[(j + 1) % 64], e_ready: 1'b1, e_err: 1'b0};
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_nsq", n_squared, 0);
    check("rst_k", k_val, 0);
    check("rst_nbit", n_bit, 0);
    check("rst_ready", ready, 0);
    check("rst_err", error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // consume before load: ignored, flagged in the check build
    pulse(1'b1, 1'b0, 1'b0);
    exp_err = exp_err | CHK;
    check("early_nsq", n_squared, 0);
    check("early_err", error, exp_err);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("idle_ready", ready, 0);
    end
    check("early_err_hold", error, exp_err);

    // load all three tables
    for (int i = 0; i < 4; i++) load_word(2'd0, 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) load_word(2'd1, 32'hB0 + 32'(i));
    check("ready_after_k", ready, 0);
    load_word(2'd2, nval[31:0]);
    check("ready_before_last", ready, 0);
    load_word(2'd2, nval[63:32]);
    check("ready_loaded", ready, 1);
    check("load_nsq", n_squared, 32'hA0);
    check("load_k", k_val, 32'hB0);
    check("load_nbit", n_bit, 1);

    // k wrap and n bit stream, back-to-back pulses
    for (int i = 0; i < 69; i++) begin
      tbl[i].e_err = exp_err;
      step(tbl[i]);
    end
    c_nsq = 1'b0;
    c_k   = 1'b0;
    c_n   = 1'b0;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d left expected 0", sb.size());
    end

    // collision: k at index 2, word-0 load wins over consume
    pulse(1'b0, 1'b1, 1'b0);
    check("coll_k_idx2", k_val, 32'hB2);
    @(negedge clk);
    load_valid = 1'b1;
    load_sel   = 2'd1;
    load_data  = 32'hC0;
    c_k        = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    c_k        = 1'b0;
    check("coll_k", k_val, 32'hC0);
    check("coll_ready", ready, 0);
    pulse(1'b0, 1'b1, 1'b1);
    exp_err = exp_err | CHK;
    check("coll_ignored_k", k_val, 32'hC0);
    check("coll_ignored_nbit", n_bit, 1);
    check("coll_err", error, exp_err);
    load_word(2'd1, 32'hC1);
    load_word(2'd1, 32'hC2);
    check("reload_partial", ready, 0);
    load_word(2'd1, 32'hC3);
    check("reload_ready", ready, 1);
    check("reload_k", k_val, 32'hC0);
    pulse(1'b1, 1'b1, 1'b0);
    check("reload_step_k", k_val, 32'hC1);
    check("reload_step_nsq", n_squared, 32'hA1);

    // select 3 load is ignored by the tables
    load_word(2'd3, 32'hDEAD_BEEF);
    exp_err = exp_err | CHK;
    check("sel3_err", error, exp_err);
    check("sel3_k", k_val, 32'hC1);
    check("sel3_ready", ready, 1);

    // asynchronous reset mid-stream
    @(negedge clk);
    c_nsq = 1'b1;
    c_k   = 1'b1;
    c_n   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_nsq", n_squared, 0);
    check("arst_k", k_val, 0);
    check("arst_nbit", n_bit, 0);
    check("arst_ready", ready, 0);
    check("arst_err", error, 0);
    c_nsq = 1'b0;
    c_k   = 1'b0;
    c_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_ready", ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
